// File: rtl/io_dev_pkg.sv
// Shared definitions for the memory-mapped I/O devices: register addresses,
// control/status bit positions and the key-device status record.
package io_dev_pkg;

    localparam logic [31:0] KDATA_ADDR = 32'hF000_0010;
    localparam logic [31:0] KCTRL_ADDR = 32'hF000_0110;

    localparam int KCTRL_READY_BIT = 0;
    localparam int KCTRL_OVR_BIT   = 2;
    localparam int KCTRL_IE_BIT    = 8;

    localparam int NUM_KEYS = 4;

    typedef struct packed {
        logic overrun;
        logic ready;
    } kstat_t;

    function automatic int debounce_cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: active-low raw input -> 2-flop synchronizer -> stability
// counter -> debounced level, plus a same-cycle pulse when the level will flip.
module key_debounce
    import io_dev_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic kdata_o,
    output logic changed_o
);

    localparam int CW = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          kdata_q, kdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            kdata_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ~key_n_i;
            sync2_q <= sync1_q;
            kdata_q <= kdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // changed_o is combinational so status logic sees it on the same edge
    // that kdata_q takes the new value.
    always_comb begin
        kdata_d   = kdata_q;
        cnt_d     = cnt_q;
        changed_o = 1'b0;
        if (sync2_q == kdata_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            kdata_d   = sync2_q;
            cnt_d     = '0;
            changed_o = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign kdata_o = kdata_q;

endmodule

// File: rtl/key_device.sv
// Memory-mapped pushbutton peripheral: debounced KDATA plus sticky KCTRL status.
// Build option KEY_INTR_EN adds the interrupt-enable bit and the intr output.
module key_device
    import io_dev_pkg::*;
#(
    parameter int ABUS_WIDTH      = 32,
    parameter int DBUS_WIDTH      = 32,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ABUS_WIDTH-1:0] aBus,
    inout  wire  [DBUS_WIDTH-1:0] dBus,
    input  logic                  wrtEn,
    input  logic [3:0]            key,
    output logic                  intr
);

    logic [NUM_KEYS-1:0]   kdata;
    logic [NUM_KEYS-1:0]   changed;
    logic                  any_change;
    logic                  rd_kdata, rd_kctrl, wr_kctrl;
    logic [DBUS_WIDTH-1:0] rd_data;
    kstat_t                stat_q, stat_d;
    logic                  ie;
    logic                  unused_dbus;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk      (clk),
            .reset    (reset),
            .key_n_i  (key[i]),
            .kdata_o  (kdata[i]),
            .changed_o(changed[i])
        );
    end

    // Bus protocol: there is no handshake. Every cycle with a matching aBus is
    // an access; wrtEn=1 means the CPU drives dBus and it is sampled at the
    // edge, wrtEn=0 means this device drives dBus combinationally all cycle.
    assign rd_kdata   = (aBus == ABUS_WIDTH'(KDATA_ADDR)) && !wrtEn;
    assign rd_kctrl   = (aBus == ABUS_WIDTH'(KCTRL_ADDR)) && !wrtEn;
    assign wr_kctrl   = (aBus == ABUS_WIDTH'(KCTRL_ADDR)) && wrtEn;
    assign any_change = |changed;
    assign unused_dbus = ^dBus;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    // A KDATA read consumes ready unless a new change lands on that same edge;
    // overrun only records a change that arrives while ready is still unread.
    always_comb begin
        stat_d = stat_q;
        if (any_change) begin
            stat_d.ready = 1'b1;
        end else if (rd_kdata) begin
            stat_d.ready = 1'b0;
        end
        if (any_change && stat_q.ready && !rd_kdata) begin
            stat_d.overrun = 1'b1;
        end else if (wr_kctrl && !dBus[KCTRL_OVR_BIT]) begin
            stat_d.overrun = 1'b0;
        end
    end

`ifdef KEY_INTR_EN
    logic ie_q, ie_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q <= 1'b0;
        end else begin
            ie_q <= ie_d;
        end
    end

    always_comb begin
        ie_d = ie_q;
        if (wr_kctrl) begin
            ie_d = dBus[KCTRL_IE_BIT];
        end
    end

    assign ie   = ie_q;
    assign intr = ie_q & stat_q.ready;
`else
    assign ie   = 1'b0;
    assign intr = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        if (rd_kdata) begin
            rd_data[NUM_KEYS-1:0] = kdata;
        end else if (rd_kctrl) begin
            rd_data[KCTRL_READY_BIT] = stat_q.ready;
            rd_data[KCTRL_OVR_BIT]   = stat_q.overrun;
            rd_data[KCTRL_IE_BIT]    = ie;
        end
    end

    assign dBus = (rd_kdata || rd_kctrl) ? rd_data : {DBUS_WIDTH{1'bz}};

endmodule
